// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with a one-entry holding register and valid/ready handshake.
// Flags framing errors and overruns as sticky bits cleared by err_clr.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t state, nxt;

  logic          rxd_m;
  logic          rxd_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic shift_en;
  logic done;
  logic ferr_set;
  logic free;
  logic load;
  logic ovr_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= uart_rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt      = state;
    shift_en = 1'b0;
    done     = 1'b0;
    ferr_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxd_s) nxt = START;
      end
      START: begin
        if (cnt == HALF) nxt = rxd_s ? IDLE : DATA;
      end
      DATA: begin
        if (cnt == LAST) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          if (rxd_s) begin
            nxt  = IDLE;
            done = 1'b1;
          end else begin
            nxt      = BRK;
            ferr_set = 1'b1;
          end
        end
      end
      BRK: begin
        if (rxd_s) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Holding register counts as free if it is being drained this cycle.
  assign free    = !rx_valid || rx_ready;
  assign load    = done && free;
  assign ovr_set = done && !free;
  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (nxt != state || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state != DATA) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 1'b1;
      end
      if (shift_en) shreg <= {rxd_s, shreg[7:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (load) begin
      rx_data  <= shreg;
      rx_valid <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ferr_set) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
